// File: rtl/maxpool2x2_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxpool2x2_unit_pkg
// Description : Shared constants and the size-check helper for the 2x2 pooling
//               stage.
// Revision    : 1.0 - initial release
// ============================================================================
package maxpool2x2_unit_pkg;

  // Pooling window edge; the window is square with stride equal to its size.
  localparam int POOL_SIZE = 2;

  // Default activation width carried between layers.
  localparam int DEFAULT_N = 16;

  // Largest activation the upstream ReLU/clamp can produce.
  localparam int ACT_MAX = 127;

  // True when a feature-map edge can be tiled exactly by the pooling window.
  function automatic bit is_even_size(input int size);
    return (size >= POOL_SIZE) && ((size % POOL_SIZE) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool2x2_unit_pool_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : pool_line_buf
// Description : Single-write, asynchronous-read register array holding the
//               horizontal maxima of the upper row of each pooling window.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_line_buf #(
  parameter int DEPTH  = 12,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage needs no reset: every entry is written on an even row before the
  // following odd row reads it.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/maxpool2x2_unit.sv
`default_nettype none
// ============================================================================
// Module      : maxpool2x2_unit
// Description : Streaming 2x2 / stride-2 max-pooling of a raster-ordered
//               square feature map, with an end-of-frame flag on the last
//               pooled sample.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool2x2_unit
  import maxpool2x2_unit_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int INPUT_SIZE = 24,
  parameter int CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         input_vld,
  input  logic [N-1:0] input_din,
  output logic [N-1:0] pool_dout,
  output logic         pool_dout_vld,
  output logic         pool_dout_end
);

  localparam int DEPTH  = INPUT_SIZE / POOL_SIZE;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_SIZE - 1);

  // Reject map sizes the window cannot tile or the counters cannot reach.
  if (!is_even_size(INPUT_SIZE) || (INPUT_SIZE > (2 ** CNT_W))) begin : g_bad_size
    $fatal(1, "maxpool2x2_unit: INPUT_SIZE must be even, >= 2 and <= 2**CNT_W");
  end

  logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
  logic [CNT_W-1:0]  row_cnt_q, row_cnt_d;
  logic [N-1:0]      hold_q, hold_d;
  logic [N-1:0]      pool_dout_q, pool_dout_d;
  logic              pool_vld_q, pool_vld_d;
  logic              pool_end_q, pool_end_d;

  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [N-1:0]      buf_rd;
  logic [N-1:0]      hmax;
  logic [N-1:0]      pmax;
  logic              col_last;
  logic              row_last;

  // Window column pair index: both pixels of a pair share one line-buffer slot.
  assign buf_addr = col_cnt_q[ADDR_W:1];

  pool_line_buf #(
    .DEPTH  (DEPTH),
    .WIDTH  (N),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk       (clk),
    .wr_en_i   (buf_we),
    .wr_addr_i (buf_addr),
    .wr_data_i (hmax),
    .rd_addr_i (buf_addr),
    .rd_data_o (buf_rd)
  );

  // Next-state decode: counter advance, phase selection and window maximum.
  always_comb begin
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    hold_d      = hold_q;
    pool_dout_d = pool_dout_q;
    pool_vld_d  = 1'b0;
    pool_end_d  = 1'b0;
    buf_we      = 1'b0;

    col_last = (col_cnt_q == LAST_IDX);
    row_last = (row_cnt_q == LAST_IDX);
    hmax     = (input_din > hold_q) ? input_din : hold_q;
    pmax     = (buf_rd > hmax) ? buf_rd : hmax;

    if (input_vld) begin
      if (col_last) begin
        col_cnt_d = '0;
        row_cnt_d = row_last ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end

      if (!col_cnt_q[0]) begin
        // Left pixel of a pair: park it until its right neighbour arrives.
        hold_d = input_din;
      end else if (!row_cnt_q[0]) begin
        // Upper row of a window: remember the pair maximum for the next row.
        buf_we = 1'b1;
      end else begin
        // Bottom-right pixel completes the window.
        pool_dout_d = pmax;
        pool_vld_d  = 1'b1;
        pool_end_d  = row_last && col_last;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      hold_q      <= '0;
      pool_dout_q <= '0;
      pool_vld_q  <= 1'b0;
      pool_end_q  <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      hold_q      <= hold_d;
      pool_dout_q <= pool_dout_d;
      pool_vld_q  <= pool_vld_d;
      pool_end_q  <= pool_end_d;
    end
  end

  assign pool_dout     = pool_dout_q;
  assign pool_dout_vld = pool_vld_q;
  assign pool_dout_end = pool_end_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpool2x2_unit
// Description : Self-checking bench for maxpool2x2_unit with a 4x4 and a
//               24x24 instance driven side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool2x2_unit;

  localparam int N   = 16;
  localparam int S4  = 4;
  localparam int S24 = 24;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         vld4  = 1'b0;
  logic         vld24 = 1'b0;
  logic [N-1:0] din4  = '0;
  logic [N-1:0] din24 = '0;
  logic [N-1:0] dout4, dout24;
  logic         dv4, de4, dv24, de24;

  always #5 clk = ~clk;

  maxpool2x2_unit #(.N(N), .INPUT_SIZE(S4), .CNT_W(8)) dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .input_vld     (vld4),
    .input_din     (din4),
    .pool_dout     (dout4),
    .pool_dout_vld (dv4),
    .pool_dout_end (de4)
  );

  maxpool2x2_unit #(.N(N), .INPUT_SIZE(S24), .CNT_W(8)) dut24 (
    .clk           (clk),
    .rst_n         (rst_n),
    .input_vld     (vld24),
    .input_din     (din24),
    .pool_dout     (dout24),
    .pool_dout_vld (dv24),
    .pool_dout_end (de24)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Scoreboards: {end_flag, data} per expected pooled sample.
  logic [N:0]   q4[$];
  logic [N:0]   q24[$];
  logic [N-1:0] last4  = '0;
  logic [N-1:0] last24 = '0;
  int           pulses24 = 0;

  // Reference model state: full image plus raster position.
  logic [N-1:0] img4  [S4][S4];
  logic [N-1:0] img24 [S24][S24];
  int r4 = 0, c4 = 0, r24 = 0, c24 = 0;

  function automatic logic [N-1:0] max2(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model4(input logic [N-1:0] d);
    img4[r4][c4] = d;
    if ((r4 % 2 == 1) && (c4 % 2 == 1)) begin
      q4.push_back({(r4 == S4-1) && (c4 == S4-1),
                    max2(max2(img4[r4-1][c4-1], img4[r4-1][c4]),
                         max2(img4[r4][c4-1], img4[r4][c4]))});
    end
    if (c4 == S4-1) begin
      c4 = 0;
      r4 = (r4 == S4-1) ? 0 : r4 + 1;
    end else begin
      c4++;
    end
  endtask

  task automatic model24(input logic [N-1:0] d);
    img24[r24][c24] = d;
    if ((r24 % 2 == 1) && (c24 % 2 == 1)) begin
      q24.push_back({(r24 == S24-1) && (c24 == S24-1),
                     max2(max2(img24[r24-1][c24-1], img24[r24-1][c24]),
                          max2(img24[r24][c24-1], img24[r24][c24]))});
    end
    if (c24 == S24-1) begin
      c24 = 0;
      r24 = (r24 == S24-1) ? 0 : r24 + 1;
    end else begin
      c24++;
    end
  endtask

  task automatic check_out();
    logic [N:0] e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("vld4", dv4, 1);
      chk("dout4", dout4, e[N-1:0]);
      chk("end4", de4, e[N]);
      last4 = e[N-1:0];
    end else begin
      chk("vld4_idle", dv4, 0);
      chk("end4_idle", de4, 0);
      chk("hold4", dout4, last4);
    end
    if (q24.size() > 0) begin
      e = q24.pop_front();
      chk("vld24", dv24, 1);
      chk("dout24", dout24, e[N-1:0]);
      chk("end24", de24, e[N]);
      last24 = e[N-1:0];
      pulses24++;
    end else begin
      chk("vld24_idle", dv24, 0);
      chk("end24_idle", de24, 0);
      chk("hold24", dout24, last24);
    end
  endtask

  // One clock: drive at the falling edge, check just after the rising edge.
  task automatic cycle(input logic v4, input logic [N-1:0] d4,
                       input logic v24, input logic [N-1:0] d24);
    @(negedge clk);
    vld4  = v4;
    din4  = d4;
    vld24 = v24;
    din24 = d24;
    if (v4)  model4(d4);
    if (v24) model24(d24);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Reset with valid inputs present, which must be ignored.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    vld4  = 1'b1;
    vld24 = 1'b1;
    din4  = 16'd99;
    din24 = 16'd99;
    q4.delete();
    q24.delete();
    r4 = 0; c4 = 0; r24 = 0; c24 = 0;
    last4 = '0;
    last24 = '0;
    pulses24 = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_out();
    end
    @(negedge clk);
    rst_n = 1'b1;
    vld4  = 1'b0;
    vld24 = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rv;

    // Reset state.
    do_reset(2);
    cycle(0, '0, 0, '0);

    // 4x4 ascending, continuous: expect 5, 7, 13, 15.
    for (int i = 0; i < 16; i++) cycle(1, 16'(i), 0, '0);
    cycle(0, '0, 0, '0);

    // 4x4 ascending with gaps, forced mid-pair and at row boundaries.
    for (int i = 0; i < 16; i++) begin
      if (i == 1 || i == 4 || i == 9 || i == 15) cycle(0, 16'hBEEF, 0, '0);
      while ($urandom_range(0, 2) == 0) cycle(0, 16'($urandom_range(0, 255)), 0, '0);
      cycle(1, 16'(i), 0, '0);
    end
    cycle(0, '0, 0, '0);

    // 4x4 descending: expect 15, 13, 7, 5.
    for (int i = 15; i >= 0; i--) cycle(1, 16'(i), 0, '0);
    cycle(0, '0, 0, '0);

    // 24x24, two back-to-back random frames.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < S24*S24; i++) begin
        rv = 16'($urandom_range(0, 127));
        cycle(0, '0, 1, rv);
      end
      chk("pulses_per_frame", pulses24, 144);
      pulses24 = 0;
    end

    // Partial frame aborted by reset, then a clean frame.
    for (int i = 0; i < 30; i++) cycle(0, '0, 1, 16'($urandom_range(0, 127)));
    do_reset(2);
    for (int i = 0; i < S24*S24; i++) cycle(0, '0, 1, 16'($urandom_range(0, 127)));
    chk("pulses_after_reset", pulses24, 144);
    pulses24 = 0;

    // Saturated frame then ReLU-dead frame.
    for (int i = 0; i < S24*S24; i++) cycle(0, '0, 1, 16'd127);
    chk("pulses_all_max", pulses24, 144);
    pulses24 = 0;
    for (int i = 0; i < S24*S24; i++) cycle(0, '0, 1, 16'd0);
    chk("pulses_all_zero", pulses24, 144);
    cycle(0, '0, 0, '0);
    cycle(0, '0, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
